// File: rtl/fan_button_conditioner.sv
// Button front end for the fan FSM: synchronises, debounces and edge-detects raw
// push-buttons, then emits a one-hot press pulse with lowest-index priority.
module fan_button_conditioner #(
  parameter int NUM_BTN         = 5,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NUM_BTN-1:0] i_btn_raw,
  output logic [NUM_BTN-1:0] o_btn_level,
  output logic [NUM_BTN-1:0] o_button,
  output logic               o_press_drop
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0]   CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [NUM_BTN-1:0] BTN_ONE  = NUM_BTN'(1);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    CHK_HI    = 2'd1,
    STABLE_HI = 2'd2,
    CHK_LO    = 2'd3
  } db_state_e;

  logic [NUM_BTN-1:0] sync_r [SYNC_STAGES];
  logic [NUM_BTN-1:0] sync_s;
  db_state_e          state_r     [NUM_BTN];
  db_state_e          state_nxt_s [NUM_BTN];
  logic [CNT_W-1:0]   cnt_r       [NUM_BTN];
  logic [CNT_W-1:0]   cnt_nxt_s   [NUM_BTN];
  logic [NUM_BTN-1:0] level_r;
  logic [NUM_BTN-1:0] level_nxt_s;
  logic [NUM_BTN-1:0] level_d_r;
  logic [NUM_BTN-1:0] rise_s;
  logic [NUM_BTN-1:0] pick_s;
  logic               multi_s;
  logic [NUM_BTN-1:0] button_r;
  logic               drop_r;

  assign sync_s = sync_r[SYNC_STAGES-1];

  // Synchroniser chain for the asynchronous button pins.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_r[k] <= '0;
      end
    end else begin
      sync_r[0] <= i_btn_raw;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_r[k] <= sync_r[k-1];
      end
    end
  end

  // Per-button debounce next-state; a level change needs DEBOUNCE_CYCLES equal samples.
  always_comb begin
    level_nxt_s = level_r;
    for (int i = 0; i < NUM_BTN; i++) begin
      state_nxt_s[i] = state_r[i];
      cnt_nxt_s[i]   = cnt_r[i];
      case (state_r[i])
        STABLE_LO: begin
          if (sync_s[i]) begin
            state_nxt_s[i] = CHK_HI;
            cnt_nxt_s[i]   = CNT_ONE;
          end else begin
            cnt_nxt_s[i]   = CNT_ZERO;
          end
        end
        CHK_HI: begin
          if (!sync_s[i]) begin
            state_nxt_s[i] = STABLE_LO;
            cnt_nxt_s[i]   = CNT_ZERO;
          end else if (cnt_r[i] == CNT_LAST) begin
            state_nxt_s[i] = STABLE_HI;
            cnt_nxt_s[i]   = CNT_ZERO;
            level_nxt_s[i] = 1'b1;
          end else begin
            cnt_nxt_s[i]   = cnt_r[i] + CNT_ONE;
          end
        end
        STABLE_HI: begin
          if (!sync_s[i]) begin
            state_nxt_s[i] = CHK_LO;
            cnt_nxt_s[i]   = CNT_ONE;
          end else begin
            cnt_nxt_s[i]   = CNT_ZERO;
          end
        end
        CHK_LO: begin
          if (sync_s[i]) begin
            state_nxt_s[i] = STABLE_HI;
            cnt_nxt_s[i]   = CNT_ZERO;
          end else if (cnt_r[i] == CNT_LAST) begin
            state_nxt_s[i] = STABLE_LO;
            cnt_nxt_s[i]   = CNT_ZERO;
            level_nxt_s[i] = 1'b0;
          end else begin
            cnt_nxt_s[i]   = cnt_r[i] + CNT_ONE;
          end
        end
        default: begin
          state_nxt_s[i] = STABLE_LO;
          cnt_nxt_s[i]   = CNT_ZERO;
          level_nxt_s[i] = 1'b0;
        end
      endcase
    end
  end

  // Debounce state, counters and accepted levels.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < NUM_BTN; i++) begin
        state_r[i] <= STABLE_LO;
        cnt_r[i]   <= CNT_ZERO;
      end
      level_r   <= '0;
      level_d_r <= '0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        state_r[i] <= state_nxt_s[i];
        cnt_r[i]   <= cnt_nxt_s[i];
      end
      level_r   <= level_nxt_s;
      level_d_r <= level_r;
    end
  end

  // Lowest set rise bit wins; x & -x isolates it, x & (x-1) is nonzero when more remain.
  always_comb begin
    rise_s  = level_r & ~level_d_r;
    pick_s  = rise_s & (~rise_s + BTN_ONE);
    multi_s = |(rise_s & (rise_s - BTN_ONE));
  end

  // Registered press pulse and drop flag.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      button_r <= '0;
      drop_r   <= 1'b0;
    end else begin
      button_r <= pick_s;
      drop_r   <= multi_s;
    end
  end

  assign o_btn_level  = level_r;
  assign o_button     = button_r;
  assign o_press_drop = drop_r;

endmodule

// File: tb/tb_fan_button_conditioner.sv
// Scoreboard bench for fan_button_conditioner: expected pulses are queued when
// buttons are driven and matched against each o_button pulse as it appears.
module tb_fan_button_conditioner;

  localparam int NB = 5;

  typedef struct {
    int            cyc;
    logic [NB-1:0] btn;
    logic          drop;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] button;
  logic          press_drop;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t exp_q [$];

  fan_button_conditioner #(
    .NUM_BTN(NB),
    .DEBOUNCE_CYCLES(4),
    .SYNC_STAGES(2)
  ) dut (
    .i_clk(clk),
    .i_reset(rst_n),
    .i_btn_raw(btn_raw),
    .o_btn_level(btn_level),
    .o_button(button),
    .o_press_drop(press_drop)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive a new raw vector; if it raises buttons, queue the expected pulse 7 clocks out.
  task automatic drive(input logic [NB-1:0] val, input logic [NB-1:0] exp_btn, input logic exp_drop);
    exp_t e;
    btn_raw = val;
    if (exp_btn != '0) begin
      e.cyc  = cyc + 7;
      e.btn  = exp_btn;
      e.drop = exp_drop;
      exp_q.push_back(e);
    end
  endtask

  // Pulse monitor: every pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1) begin
      if (button != '0) begin
        if (exp_q.size() == 0) begin
          check_val("unexpected_pulse", {27'd0, button}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_val("pulse_cycle", cyc, e.cyc);
          check_val("pulse_button", {27'd0, button}, {27'd0, e.btn});
          check_val("pulse_drop", {31'd0, press_drop}, {31'd0, e.drop});
        end
      end else if (press_drop !== 1'b0) begin
        check_val("drop_without_pulse", {31'd0, press_drop}, 32'd0);
      end
    end
  end

  logic [NB-1:0] seq [6];
  int t0;

  initial begin
    seq[0] = 5'b00001; seq[1] = 5'b00010; seq[2] = 5'b00100;
    seq[3] = 5'b01000; seq[4] = 5'b10000; seq[5] = 5'b01000;
    rst_n   = 1'b0;
    btn_raw = 5'b00000;

    // 1: reset then clean press
    tick(10);
    check_val("rst_level", {27'd0, btn_level}, 32'd0);
    check_val("rst_button", {27'd0, button}, 32'd0);
    check_val("rst_drop", {31'd0, press_drop}, 32'd0);
    rst_n = 1'b1;
    tick(2);
    t0 = cyc;
    drive(5'b00010, 5'b00010, 1'b0);
    tick(5);
    check_val("t1_level_early", {27'd0, btn_level}, 32'd0);
    tick(1);
    check_val("t1_level", {27'd0, btn_level}, 32'h02);
    tick(20);
    drive(5'b00000, 5'b00000, 1'b0);
    tick(8);
    check_val("t1_release", {27'd0, btn_level}, 32'd0);

    // 2: bounce on bit 0 must be rejected, then a real press
    drive(5'b00001, 5'b00000, 1'b0); tick(1);
    drive(5'b00001, 5'b00000, 1'b0); tick(1);
    drive(5'b00000, 5'b00000, 1'b0); tick(1);
    drive(5'b00001, 5'b00000, 1'b0); tick(1);
    drive(5'b00001, 5'b00000, 1'b0); tick(1);
    drive(5'b00001, 5'b00000, 1'b0); tick(1);
    drive(5'b00000, 5'b00000, 1'b0);
    for (int k = 0; k < 8; k++) begin
      tick(1);
      check_val("t2_bounce_level", {27'd0, btn_level}, 32'd0);
    end
    drive(5'b00001, 5'b00001, 1'b0);
    tick(10);
    check_val("t2_level", {27'd0, btn_level}, 32'h01);
    drive(5'b00000, 5'b00000, 1'b0);
    tick(8);

    // 3: simultaneous press of bits 2 and 4
    drive(5'b10100, 5'b00100, 1'b1);
    tick(8);
    check_val("t3_level", {27'd0, btn_level}, 32'h14);
    drive(5'b00000, 5'b00000, 1'b0);
    tick(8);
    check_val("t3_release", {27'd0, btn_level}, 32'd0);

    // 4: staggered press, staggered release
    drive(5'b00010, 5'b00010, 1'b0);
    tick(3);
    drive(5'b01010, 5'b01000, 1'b0);
    tick(10);
    check_val("t4_level_both", {27'd0, btn_level}, 32'h0a);
    drive(5'b01000, 5'b00000, 1'b0);
    tick(5);
    check_val("t4_rel1_early", {27'd0, btn_level}, 32'h0a);
    tick(1);
    check_val("t4_rel1", {27'd0, btn_level}, 32'h08);
    drive(5'b00000, 5'b00000, 1'b0);
    tick(5);
    check_val("t4_rel3_early", {27'd0, btn_level}, 32'h08);
    tick(1);
    check_val("t4_rel3", {27'd0, btn_level}, 32'd0);
    tick(4);

    // 5: reset mid-count, release with button still held
    drive(5'b01000, 5'b00000, 1'b0);
    tick(5);
    rst_n = 1'b0;
    #1;
    check_val("t5_rst_level", {27'd0, btn_level}, 32'd0);
    check_val("t5_rst_button", {27'd0, button}, 32'd0);
    tick(3);
    drive(5'b01000, 5'b01000, 1'b0);
    rst_n = 1'b1;
    tick(10);
    check_val("t5_level", {27'd0, btn_level}, 32'h08);
    drive(5'b00000, 5'b00000, 1'b0);
    tick(8);

    // 6: fan sequence replay
    for (int k = 0; k < 6; k++) begin
      drive(seq[k], seq[k], 1'b0);
      tick(20);
      check_val("t6_level", {27'd0, btn_level}, {27'd0, seq[k]});
      drive(5'b00000, 5'b00000, 1'b0);
      tick(20);
    end

    tick(10);
    check_val("queue_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fan_button_conditioner.md
Name: fan_button_conditioner

Overview:
- Front end that produces the one-hot i_button interface consumed by the fan FSM; this block is the producer side of that interface.
- Takes 5 raw, bouncy, asynchronous push-button inputs from the board.
- Synchronises, debounces and edge-detects them.
- Emits a clean one-hot press pulse and a debounced level vector. The fan FSM sees at most one button event per clock.

Parameters:
NUM_BTN, 5, number of buttons (bit 0 = off, bits 1..3 = speed 1..3, bit 4 = timer/mode).
DEBOUNCE_CYCLES, 100000, consecutive stable samples required to accept a level change; minimum 2; benches use 4.
SYNC_STAGES, 2, flip-flop synchroniser depth per button; minimum 2.

Ports:
i_clk  input  1  system clock, all logic on the rising edge.
i_reset  input  1  asynchronous, active-low reset (0 = reset).
i_btn_raw  input  NUM_BTN  raw button pins, active-high, asynchronous to i_clk.
o_btn_level  output  NUM_BTN  debounced, registered button levels.
o_button  output  NUM_BTN  one-cycle, one-hot press pulse; feeds fan FSM i_button.
o_press_drop  output  1  one-cycle flag: a simultaneous press was discarded.

Behaviour:
- Reset (i_reset=0, asynchronous): all synchroniser flops, stable levels, counters and outputs clear to 0. o_btn_level=0, o_button=0, o_press_drop=0. Release is synchronous to i_clk through the normal flops; no output pulse is generated on release from reset.
- Synchroniser: each bit passes through a SYNC_STAGES-deep flop chain. Its last stage is sync[i].
- Per-button debounce state machine, independent per bit, with states STABLE_LO, CHK_HI, STABLE_HI, CHK_LO.
  - STABLE_LO: if sync[i]=1, go to CHK_HI with cnt=1; else stay with cnt=0.
  - CHK_HI: if sync[i]=0, return to STABLE_LO with cnt=0 (glitch rejected). Else if cnt=DEBOUNCE_CYCLES-1, go to STABLE_HI, set level[i]=1, cnt=0. Else cnt+1.
  - STABLE_HI and CHK_LO: mirror image, clearing level[i] to 0.
  - cnt width is $clog2(DEBOUNCE_CYCLES)+1 bits; it never wraps (it is cleared on every state exit).
- o_btn_level[i] = level[i], registered.
- Latency from raw edge to o_btn_level edge is exactly SYNC_STAGES+DEBOUNCE_CYCLES clocks, given a raw change set up before edge 0 and held.
- Rise detect: rise[i] = level[i] & ~level_d[i], where level_d is level delayed one clock.
- Press arbitration:
  - o_button is registered one-hot of the lowest-index set bit of rise. It is high for exactly 1 clock, one clock after level[i] rises.
  - Total latency from raw press to o_button pulse: SYNC_STAGES+DEBOUNCE_CYCLES+1 clocks.
- Simultaneous rises in the same cycle: the lowest index wins. The others are discarded, not queued. o_press_drop=1 in the same cycle as that o_button pulse.
- Rises in different cycles each produce their own pulse, even while earlier buttons are still held.
- Releases (level 1->0) generate no pulse.
- A held button produces exactly one pulse; there is no auto-repeat.
- Bounce shorter than DEBOUNCE_CYCLES samples on either edge causes no level change and no pulse.
- Reset asserted mid-count or mid-pulse: everything clears immediately. A button still held at reset release is re-debounced and produces a fresh pulse after the full latency.
- o_button is never multi-hot; o_button and o_btn_level are glitch-free registered outputs.

Test Plan:
Use DEBOUNCE_CYCLES=4 and SYNC_STAGES=2 throughout.
1. Reset and clean press: hold i_reset=0 for 10 clocks, then release. Set i_btn_raw=5'b00010 and hold -> o_btn_level=5'b00010 exactly 6 clocks later. o_button=5'b00010 for exactly 1 clock at clock 7. No further pulses while held.
2. Bounce rejection: toggle bit 0 as 1,1,0,1,1,1,0 (one value per clock), then hold 0 -> o_btn_level stays 0, o_button never asserts. Then hold 1 for 6+ clocks -> single pulse 5'b00001.
3. Simultaneous press: raise bits 2 and 4 on the same clock -> o_button=5'b00100 with o_press_drop=1 in that cycle. o_btn_level=5'b10100; no pulse for bit 4.
4. Staggered press and release: press bit 1, then press bit 3 three clocks later -> two pulses, 5'b00010 then 5'b01000, three clocks apart. Release both -> no pulses, and o_btn_level returns to 0 six clocks after each release.
5. Reset mid-operation: assert i_reset=0 two clocks after bit 3 is first seen high in CHK_HI -> all outputs are 0 immediately. Release reset with the button still held -> pulse 5'b01000 7 clocks after release.
6. Fan sequence replay: press one at a time 00001, 00010, 00100, 01000, 10000, 01000, holding each 20 clocks with 20-clock gaps -> six single-cycle one-hot pulses matching that order, o_press_drop never asserts.
